poly_addsub_stream: RTL and testbench
=====================================

POLY_ADDSUB_STREAM -- requirements
Module: poly_addsub_stream

Interface
REQ-001 SHALL have parameter LANES, default 4, coefficients per beat; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter LEN_Q, default 12, coefficient width in bits.
REQ-003 SHALL have parameter Q, default 3329, modulus; must satisfy Q < 2**LEN_Q.
REQ-004 SHALL have parameter N, default 256, coefficients per polynomial; must be a multiple of LANES.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port start_i  input  1  single-cycle pulse that begins one polynomial operation.
REQ-008 SHALL have port mode_i  input  2  operation, sampled on an accepted start: 00 add, 01 sub (a-b), 10 pass a, 11 treated as add.
REQ-009 SHALL have port valid_i  input  1  input beat valid.
REQ-010 SHALL have port ready_o  output  1  input beat accepted when valid_i && ready_o.
REQ-011 SHALL have port a_i  input  LANES*LEN_Q  operand A; lane k is bits [k*LEN_Q +: LEN_Q].
REQ-012 SHALL have port b_i  input  LANES*LEN_Q  operand B, with the same lane packing as a_i.
REQ-013 SHALL have port valid_o  output  1  result beat valid.
REQ-014 SHALL have port ready_i  input  1  downstream ready.
REQ-015 SHALL have port c_o  output  LANES*LEN_Q  result, with the same lane packing as a_i.
REQ-016 SHALL have port last_o  output  1  high together with the final result beat of a polynomial.
REQ-017 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-018 SHALL have port err_o  output  1  sticky flag: an accepted input coefficient was >= Q.

Function
REQ-019 SHALL implement a state machine with three states:
- IDLE: a start_i pulse latches mode_i, clears the beat counter and err_o, and moves to RUN.
- RUN: beats are accepted until N/LANES beats have been accepted, then the state moves to DRAIN.
- DRAIN: the state returns to IDLE in the cycle after the last result beat is transferred (valid_o && ready_i && last_o).
REQ-020 SHALL ignore start_i outside IDLE; mode, counter and err_o are unaffected.
REQ-021 SHALL use a global pipeline enable en = !valid_o || ready_i, and drive ready_o = (state==RUN) && en.
REQ-022 SHALL use a two-stage pipeline:
- Stage 1 registers the raw LEN_Q+1-bit result t per lane.
- Stage 2 registers the reduced result.
- Latency from input accept to valid_o is exactly 2 cycles when ready_i is held high.
REQ-023 SHALL accept one beat per cycle at full throughput, with no bubbles while valid_i and ready_i stay high.
REQ-024 SHALL hold c_o, valid_o and last_o stable while valid_o && !ready_i.
REQ-025 SHALL compute t per mode:
- add: t = a + b.
- sub: t = a + Q - b.
- pass: t = a.
- All arithmetic in LEN_Q+1 bits.
REQ-026 SHALL reduce c = (t >= Q) ? t - Q : t, truncated to LEN_Q bits; this is exact for inputs < Q.
REQ-027 SHALL set err_o on any accepted beat with any lane of a_i >= Q, or of b_i >= Q in add/sub mode; the result is still computed per REQ-025/026.
REQ-028 SHALL use a beat counter of width clog2(N/LANES)+1 and tag the beat with index N/LANES-1 so that last_o appears with its result.
REQ-029 SHALL ignore valid_i outside RUN; ready_o stays low there.

Reset
REQ-030 SHALL, while rst_n_i is low, asynchronously force:
- state = IDLE and all counters = 0;
- ready_o = 0, valid_o = 0, last_o = 0, busy_o = 0, err_o = 0, c_o = 0;
- every pipeline valid bit cleared.
REQ-031 SHALL discard any in-flight polynomial on reset assertion mid-operation; no partial beats are output after release.
REQ-032 SHALL accept start_i in the first clock edge after rst_n_i deasserts.

Verification
REQ-033 Add, LANES=4, ready_i=1: all lanes a=3328, b=1, plus a=100, b=200 -> c=0, then 300; valid_o 2 cycles after each accept; 64 beats; last_o on beat 63 only.
REQ-034 Sub: a=0, b=1 -> c=3328; a=5, b=5 -> 0; a=3328, b=0 -> 3328; pass mode: a=1234 -> 1234.
REQ-035 Backpressure: ready_i toggled pseudo-randomly over a full polynomial -> output stream identical to the ready_i=1 run; c_o stable while stalled; no beat lost or duplicated.
REQ-036 start_i during RUN with a different mode_i -> ignored; results use the original mode; busy_o drops exactly once, after the last_o transfer.
REQ-037 rst_n_i pulsed low at beat 20 -> all outputs 0 immediately; a new start then produces a complete 64-beat polynomial with correct last_o.
REQ-038 Lane value 3329 on beat 7 -> err_o = 1 from the cycle after the accept until the next accepted start; parameter sweep LANES in {1, 16} repeats REQ-033.

Source files
------------

// File: rtl/poly_addsub_stream.sv
// Streaming modular add/sub/pass over polynomial coefficients, LANES per beat,
// through a two-stage pipeline (raw sum, then single conditional reduction).
module poly_addsub_stream #(
    parameter int unsigned LANES = 4,
    parameter int unsigned LEN_Q = 12,
    parameter int unsigned Q     = 3329,
    parameter int unsigned N     = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic [1:0]             mode_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [LANES*LEN_Q-1:0] a_i,
    input  logic [LANES*LEN_Q-1:0] b_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [LANES*LEN_Q-1:0] c_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int unsigned TW = LEN_Q + 1;
    localparam int unsigned NB = N / LANES;
    localparam int unsigned CW = $clog2(NB) + 1;
    localparam int unsigned DW = LANES * LEN_Q;
    localparam int unsigned PW = LANES * TW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      mode_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;
    logic            v1_q, l1_q, v2_q, l2_q;
    logic [PW-1:0]   t_q;
    logic [DW-1:0]   c_q;

    logic            en_c, acc_c, start_c, final_c, bad_c;
    logic            sub_c, pass_c;
    logic [PW-1:0]   t_c;
    logic [DW-1:0]   c_c;
    logic [LANES-1:0] bad_lane_c;

    assign sub_c   = (mode_q == 2'b01);
    assign pass_c  = (mode_q == 2'b10);
    assign en_c    = !v2_q || ready_i;
    assign start_c = (state_q == ST_IDLE) && start_i;
    assign acc_c   = valid_i && ready_o;
    assign final_c = acc_c && (cnt_q == CW'(NB - 1));
    assign bad_c   = |bad_lane_c;

    // Per-lane arithmetic: stage-1 raw result and stage-2 single-step reduction
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LEN_Q-1:0] a_l, b_l;
        logic [TW-1:0]    t_l, r_l, r_sub_l;

        assign a_l = a_i[k*LEN_Q +: LEN_Q];
        assign b_l = b_i[k*LEN_Q +: LEN_Q];

        always_comb begin
            t_l = TW'(a_l) + TW'(b_l);
            if (pass_c) begin
                t_l = TW'(a_l);
            end else if (sub_c) begin
                t_l = TW'(a_l) + TW'(Q) - TW'(b_l);
            end
        end

        assign t_c[k*TW +: TW] = t_l;
        assign bad_lane_c[k]   = (a_l >= LEN_Q'(Q)) || (!pass_c && (b_l >= LEN_Q'(Q)));

        assign r_l     = t_q[k*TW +: TW];
        assign r_sub_l = r_l - TW'(Q);
        assign c_c[k*LEN_Q +: LEN_Q] = (r_l >= TW'(Q)) ? LEN_Q'(r_sub_l) : LEN_Q'(r_l);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_RUN;
            ST_RUN:   if (final_c) state_d = ST_DRAIN;
            ST_DRAIN: if (v2_q && ready_i && l2_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        if (state_q == ST_RUN) begin
            ready_o = en_c;
        end
        if (state_q != ST_IDLE) begin
            busy_o = 1'b1;
        end
    end

    // Control registers and pipeline; whole pipe freezes when the output stalls
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q <= 2'b00;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
            t_q    <= '0;
            v2_q   <= 1'b0;
            l2_q   <= 1'b0;
            c_q    <= '0;
        end else begin
            if (start_c) begin
                mode_q <= mode_i;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end else if (acc_c) begin
                cnt_q <= cnt_q + CW'(1);
                if (bad_c) begin
                    err_q <= 1'b1;
                end
            end
            if (en_c) begin
                v1_q <= acc_c;
                l1_q <= final_c;
                t_q  <= t_c;
                v2_q <= v1_q;
                l2_q <= l1_q;
                c_q  <= c_c;
            end
        end
    end

    assign valid_o = v2_q;
    assign last_o  = l2_q;
    assign c_o     = c_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_poly_addsub_stream.sv
// Bench for poly_addsub_stream: directed polynomials against a modular-arithmetic
// scoreboard, plus literal pins, reset/err/backpressure cases and a LANES sweep.
module tb_poly_addsub_stream;

    localparam int LANES = 4;
    localparam int LEN_Q = 12;
    localparam int Q     = 3329;
    localparam int N     = 256;
    localparam int NB    = N / LANES;
    localparam int DW    = LANES * LEN_Q;

    logic          clk = 1'b0;
    logic          rst_n_i, start_i, valid_i, ready_i;
    logic [1:0]    mode_i;
    logic [DW-1:0] a_i, b_i, c_o;
    logic          ready_o, valid_o, last_o, busy_o, err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    poly_addsub_stream #(.LANES(LANES), .LEN_Q(LEN_Q), .Q(Q), .N(N)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .c_o     (c_o),
        .last_o  (last_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Stimulus data per test kind, beat j, lane k
    function automatic int fa(input int kind, input int j, input int k);
        if (kind == 0 && j == 0) return 3328;
        if (kind == 0 && j == 1) return 100;
        if (kind == 1 && j == 0) return 0;
        if (kind == 1 && j == 1) return 5;
        if (kind == 1 && j == 2) return 3328;
        if (kind == 2 && j == 0) return 1234;
        if (kind == 3 && j == 7 && k == 2) return 3329;
        return (j * 53 + k * 11 + kind * 7) % Q;
    endfunction

    function automatic int fb(input int kind, input int j, input int k);
        if (kind == 0 && j == 0) return 1;
        if (kind == 0 && j == 1) return 200;
        if (kind == 1 && j == 0) return 1;
        if (kind == 1 && j == 1) return 5;
        if (kind == 1 && j == 2) return 0;
        if (kind == 2 && j == 0) return 4000;
        return (j * 97 + k * 3 + 1 + kind) % Q;
    endfunction

    function automatic int mdl(input logic [1:0] md, input int a, input int b);
        if (md == 2'b01) return (a + Q - b) % Q;
        if (md == 2'b10) return a % Q;
        return (a + b) % Q;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [DW-1:0] c;
        bit            last;
    } beat_t;

    beat_t         exp_q[$];
    logic [1:0]    mode_m;
    int            acc_idx, xfer_idx, cyc;
    int            first_acc_cyc, last_acc_cyc, first_val_cyc;
    int            out0[3];
    int            busy_falls;
    bit            exp_err, poly_active, bp_en;
    bit            last_done, prev_busy, prev_stall, prev_last;
    logic [DW-1:0] prev_c, ev;
    beat_t         e;
    int            av, bv;
    bit            bd;

    initial begin
        cyc = 0; acc_idx = 0; xfer_idx = 0; busy_falls = 0;
        exp_err = 0; last_done = 0; prev_busy = 0; prev_stall = 0;
        mode_m = 2'b00;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n_i) begin
            exp_q.delete();
            exp_err = 0; acc_idx = 0; xfer_idx = 0;
            prev_stall = 0; prev_busy = 0; last_done = 0;
        end else begin
            chk("err_o", err_o, exp_err);
            if (!poly_active) chk("ready_o_idle", ready_o, 0);
            if (prev_stall) begin
                chk("stall_valid", valid_o, 1);
                chk("stall_last", last_o, prev_last);
                total++;
                if (c_o !== prev_c) begin
                    bad++;
                    $display("FAIL stall_c: got %h expected %h", c_o, prev_c);
                end
            end
            if (prev_busy && !busy_o) begin
                busy_falls++;
                chk("busy_after_last", last_done, 1);
                last_done = 0;
            end
            if (valid_o && ready_i) begin
                if (xfer_idx == 0) first_val_cyc = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat: got c=%h expected none", c_o);
                end else begin
                    e = exp_q.pop_front();
                    if (c_o !== e.c) begin
                        bad++;
                        $display("FAIL c_o beat %0d: got %h expected %h", xfer_idx, c_o, e.c);
                    end
                    chk("last_o", last_o, e.last);
                end
                if (xfer_idx < 3) out0[xfer_idx] = int'(c_o[LEN_Q-1:0]);
                if (last_o) last_done = 1;
                xfer_idx++;
            end
            if (start_i && !poly_active) begin
                mode_m   = mode_i;
                acc_idx  = 0;
                xfer_idx = 0;
                exp_err  = 0;
            end
            if (valid_i && ready_o) begin
                bd = 0;
                for (int k = 0; k < LANES; k++) begin
                    av = int'(a_i[k*LEN_Q +: LEN_Q]);
                    bv = int'(b_i[k*LEN_Q +: LEN_Q]);
                    ev[k*LEN_Q +: LEN_Q] = LEN_Q'(mdl(mode_m, av, bv));
                    if (av >= Q || (mode_m != 2'b10 && bv >= Q)) bd = 1;
                end
                exp_q.push_back('{c: ev, last: (acc_idx == NB - 1)});
                if (acc_idx == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                acc_idx++;
                if (bd) exp_err = 1;
            end
            prev_stall = valid_o && !ready_i;
            prev_c     = c_o;
            prev_last  = last_o;
            prev_busy  = busy_o;
        end
    end

    // ---------------- driver ----------------
    task automatic run_poly(input logic [1:0] md, input int kind, input bit bp,
                            input bit ign_start, input bit abort20);
        int  falls0, w;
        bit  acc;
        falls0 = busy_falls;
        bp_en   = bp;
        start_i = 1'b1;
        mode_i  = md;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        mode_i  = 2'b10;
        poly_active = 1;
        chk("busy_after_start", busy_o, 1);
        for (int j = 0; j < NB; j++) begin
            if (abort20 && j == 20) begin
                #2;
                rst_n_i = 1'b0;
                #1;
                chk("rst_ready_o", ready_o, 0);
                chk("rst_valid_o", valid_o, 0);
                chk("rst_last_o", last_o, 0);
                chk("rst_busy_o", busy_o, 0);
                chk("rst_err_o", err_o, 0);
                chk("rst_c_o", longint'(c_o), 0);
                poly_active = 0;
                valid_i = 1'b0;
                bp_en = 0;
                @(posedge clk);
                #1;
                rst_n_i = 1'b1;
                return;
            end
            valid_i = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                a_i[k*LEN_Q +: LEN_Q] = LEN_Q'(fa(kind, j, k));
                b_i[k*LEN_Q +: LEN_Q] = LEN_Q'(fb(kind, j, k));
            end
            if (ign_start && j == 30) begin
                start_i = 1'b1;
                mode_i  = 2'b00;
            end
            acc = 0;
            w = 0;
            while (!acc && w < 200) begin
                @(negedge clk);
                acc = ready_o;
                @(posedge clk);
                #1;
                w++;
            end
            start_i = 1'b0;
            if (!acc) begin
                total++; bad++;
                $display("FAIL ready_timeout: beat %0d not accepted in %0d cycles", j, w);
                valid_i = 1'b0;
                poly_active = 0;
                bp_en = 0;
                return;
            end
        end
        valid_i = 1'b0;
        w = 0;
        while (busy_o && w < 1000) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        bp_en = 0;
        chk("drain_timeout", busy_o, 0);
        chk("queue_empty", exp_q.size(), 0);
        chk("busy_falls", busy_falls - falls0, 1);
        poly_active = 0;
    endtask

    // ---------------- LANES sweep (1 and 16), add pattern ----------------
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int SL  = (g == 0) ? 1 : 16;
        localparam int SNB = N / SL;
        localparam int SDW = SL * LEN_Q;

        logic           s_start, s_valid, s_ready, s_vo, s_last, s_busy, s_err;
        logic [SDW-1:0] s_a, s_b, s_c, s_ev;
        bit             done_s = 0;
        bit             go_s   = 0;
        int             s_m    = 0;

        poly_addsub_stream #(.LANES(SL), .LEN_Q(LEN_Q), .Q(Q), .N(N)) u_sdut (
            .clk_i   (clk),
            .rst_n_i (rst_n_i),
            .start_i (s_start),
            .mode_i  (2'b00),
            .valid_i (s_valid),
            .ready_o (s_ready),
            .a_i     (s_a),
            .b_i     (s_b),
            .valid_o (s_vo),
            .ready_i (1'b1),
            .c_o     (s_c),
            .last_o  (s_last),
            .busy_o  (s_busy),
            .err_o   (s_err)
        );

        initial begin
            int w;
            bit acc;
            s_start = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0;
            wait (go_s);
            @(posedge clk);
            #1;
            s_start = 1'b1;
            @(posedge clk);
            #1;
            s_start = 1'b0;
            for (int j = 0; j < SNB; j++) begin
                s_valid = 1'b1;
                for (int k = 0; k < SL; k++) begin
                    s_a[k*LEN_Q +: LEN_Q] = LEN_Q'(fa(0, j, k));
                    s_b[k*LEN_Q +: LEN_Q] = LEN_Q'(fb(0, j, k));
                end
                acc = 0;
                w = 0;
                while (!acc && w < 100) begin
                    @(negedge clk);
                    acc = s_ready;
                    @(posedge clk);
                    #1;
                    w++;
                end
                if (!acc) begin
                    total++; bad++;
                    $display("FAIL sweep%0d_timeout: beat %0d not accepted", SL, j);
                    break;
                end
            end
            s_valid = 1'b0;
            w = 0;
            while (s_busy && w < 500) begin
                @(posedge clk);
                w++;
            end
            #2;
            chk($sformatf("sweep%0d_beats", SL), s_m, SNB);
            chk($sformatf("sweep%0d_err", SL), s_err, 0);
            done_s = 1;
        end

        always @(negedge clk) begin
            if (rst_n_i && s_vo) begin
                for (int k = 0; k < SL; k++)
                    s_ev[k*LEN_Q +: LEN_Q] = LEN_Q'(mdl(2'b00, fa(0, s_m, k), fb(0, s_m, k)));
                total++;
                if (s_c !== s_ev) begin
                    bad++;
                    $display("FAIL sweep%0d_c beat %0d: got %h expected %h", SL, s_m, s_c, s_ev);
                end
                chk($sformatf("sweep%0d_last", SL), s_last, (s_m == SNB - 1));
                s_m++;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        rst_n_i = 1'b0; start_i = 1'b0; valid_i = 1'b0; mode_i = 2'b00;
        a_i = '0; b_i = '0; bp_en = 0; poly_active = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_ready_o", ready_o, 0);
        chk("init_valid_o", valid_o, 0);
        chk("init_last_o", last_o, 0);
        chk("init_busy_o", busy_o, 0);
        chk("init_err_o", err_o, 0);
        chk("init_c_o", longint'(c_o), 0);
        rst_n_i = 1'b1;

        run_poly(2'b00, 0, 0, 0, 0);
        chk("add_beat0", out0[0], 0);
        chk("add_beat1", out0[1], 300);
        chk("add_latency", first_val_cyc - first_acc_cyc, 2);
        chk("add_throughput", last_acc_cyc - first_acc_cyc, NB - 1);

        run_poly(2'b01, 1, 0, 0, 0);
        chk("sub_0_1", out0[0], 3328);
        chk("sub_5_5", out0[1], 0);
        chk("sub_3328_0", out0[2], 3328);

        run_poly(2'b10, 2, 0, 0, 0);
        chk("pass_1234", out0[0], 1234);

        run_poly(2'b00, 0, 1, 0, 0);
        chk("bp_beat1", out0[1], 300);

        run_poly(2'b01, 1, 0, 1, 0);
        chk("ign_start_sub", out0[0], 3328);

        run_poly(2'b11, 3, 0, 0, 0);
        chk("err_sticky", err_o, 1);

        run_poly(2'b00, 0, 0, 0, 1);
        run_poly(2'b00, 0, 0, 0, 0);
        chk("post_rst_beat0", out0[0], 0);
        chk("post_rst_beat1", out0[1], 300);
        chk("post_rst_err", err_o, 0);

        g_sweep[0].go_s = 1;
        g_sweep[1].go_s = 1;
        w = 0;
        while (!(g_sweep[0].done_s && g_sweep[1].done_s) && w < 5000) begin
            @(posedge clk);
            w++;
        end
        chk("sweep_done", g_sweep[0].done_s && g_sweep[1].done_s, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
